// File: rtl/param_file_reg_if.sv
// Bus bundle for the parametrised register file: one write port, a clear
// request with its busy indication, and two registered read ports.
interface param_file_reg_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              FR_WE;
    logic [ADDR_W-1:0] FR_Waddr;
    logic [DATA_W-1:0] FR_Wdata;
    logic              FR_Clr;
    logic              FR_Busy;
    logic [ADDR_W-1:0] FR_RAddr_1;
    logic [DATA_W-1:0] FR_Rdata_1;
    logic [ADDR_W-1:0] FR_RAddr_2;
    logic [DATA_W-1:0] FR_Rdata_2;

    // Requester side: decode / write-back stages.
    modport master (
        output FR_WE, FR_Waddr, FR_Wdata, FR_Clr, FR_RAddr_1, FR_RAddr_2,
        input  FR_Busy, FR_Rdata_1, FR_Rdata_2
    );

    // Register file side.
    modport slave (
        input  FR_WE, FR_Waddr, FR_Wdata, FR_Clr, FR_RAddr_1, FR_RAddr_2,
        output FR_Busy, FR_Rdata_1, FR_Rdata_2
    );
endinterface

// File: rtl/param_file_reg.sv
// Parametrised dual-read, single-write register file with registered read
// ports, optional write-to-read forwarding, optional hardwired-zero entry 0
// and a clear sequencer that rewrites the power-on pattern one entry per
// cycle without asserting reset.
module param_file_reg #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst,
    param_file_reg_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_e;

    // Depth widened by one bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L    = ADDR_W'(DEPTH - 32'sd1);
    localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};
    localparam bit                BYPASS_EN = 1'(BYPASS);
    localparam bit                R0_EN     = 1'(R0_ZERO);

    // Power-on content of entry idx: idx modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
        return DATA_W'(idx);
    endfunction

    // True when an address maps onto a real, non-hardwired entry.
    function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
        logic live;
        live = ({1'b0, addr} < DEPTH_L);
        if (R0_EN && (addr == ZERO_A)) begin
            live = 1'b0;
        end else begin
            live = live;
        end
        return live;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    clr_state_e        state_r;
    logic              busy_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [DATA_W-1:0] rdata1_r;
    logic [DATA_W-1:0] rdata2_r;

    logic              wr_ok_s;
    logic              sweep_we_s;
    logic [DATA_W-1:0] rd1_nxt_s;
    logic [DATA_W-1:0] rd2_nxt_s;

    // Qualify the user write: idle, in range, and not aimed at a hardwired entry 0.
    always_comb begin
        wr_ok_s    = 1'b0;
        sweep_we_s = (state_r == ST_SWEEP);
        if (bus.FR_WE && !busy_r && addr_live(bus.FR_Waddr)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Next read data for port 1: dead address -> 0, else forwarded or stored value.
    always_comb begin
        rd1_nxt_s = ZERO_D;
        if (!addr_live(bus.FR_RAddr_1)) begin
            rd1_nxt_s = ZERO_D;
        end else if (BYPASS_EN && wr_ok_s && (bus.FR_Waddr == bus.FR_RAddr_1)) begin
            rd1_nxt_s = bus.FR_Wdata;
        end else begin
            rd1_nxt_s = mem_r[bus.FR_RAddr_1];
        end
    end

    // Next read data for port 2: same selection as port 1, independent address.
    always_comb begin
        rd2_nxt_s = ZERO_D;
        if (!addr_live(bus.FR_RAddr_2)) begin
            rd2_nxt_s = ZERO_D;
        end else if (BYPASS_EN && wr_ok_s && (bus.FR_Waddr == bus.FR_RAddr_2)) begin
            rd2_nxt_s = bus.FR_Wdata;
        end else begin
            rd2_nxt_s = mem_r[bus.FR_RAddr_2];
        end
    end

    // Clear sequencer: IDLE waits for a clear pulse, SWEEP walks entries 0..DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= ZERO_A;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.FR_Clr) begin
                        state_r <= ST_SWEEP;
                        busy_r  <= 1'b1;
                        cnt_r   <= ZERO_A;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    // A clear request here is deliberately ignored.
                    cnt_r <= cnt_r + ONE_A;
                    if (cnt_r == LAST_L) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_SWEEP;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= ZERO_A;
                end
            endcase
        end
    end

    // Storage array: reset loads the pattern, sweep rewrites it, otherwise user writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                mem_r[i] <= init_val(ADDR_W'(i));
            end
        end else if (sweep_we_s) begin
            mem_r[cnt_r] <= init_val(cnt_r);
        end else if (wr_ok_s) begin
            mem_r[bus.FR_Waddr] <= bus.FR_Wdata;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata1_r <= ZERO_D;
            rdata2_r <= ZERO_D;
        end else begin
            rdata1_r <= rd1_nxt_s;
            rdata2_r <= rd2_nxt_s;
        end
    end

    assign bus.FR_Busy    = busy_r;
    assign bus.FR_Rdata_1 = rdata1_r;
    assign bus.FR_Rdata_2 = rdata2_r;

endmodule

// File: tb/tb_param_file_reg.sv
// Directed and randomised bench for param_file_reg. A default-configured
// instance is checked against a behavioural model through a queue of
// predicted outputs; a second instance (DEPTH=20, BYPASS=0, R0_ZERO=1)
// covers the boundary and no-forwarding behaviour with fixed expectations.
module tb_param_file_reg;

    localparam int DEP = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt;

    param_file_reg_if #(.DATA_W(8), .ADDR_W(5)) bus_m ();
    param_file_reg_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();

    param_file_reg #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .BYPASS(1), .R0_ZERO(0)) dut_main (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    param_file_reg #(.DATA_W(8), .DEPTH(20), .ADDR_W(5), .BYPASS(0), .R0_ZERO(1)) dut_alt (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    typedef struct packed {
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic       busy;
    } exp_t;

    exp_t       q_m[$];
    exp_t       q_a[$];
    logic [7:0] mdl [DEP];
    logic       mdl_busy;
    int         mdl_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < DEP; i++) mdl[i] = 8'(i);
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
    endtask

    // Predict the main instance's outputs after the coming edge and advance the model.
    task automatic mdl_step();
        logic wr_ok;
        exp_t e;
        wr_ok = bus_m.FR_WE && !mdl_busy;
        e.rd1 = (wr_ok && bus_m.FR_Waddr == bus_m.FR_RAddr_1) ? bus_m.FR_Wdata : mdl[bus_m.FR_RAddr_1];
        e.rd2 = (wr_ok && bus_m.FR_Waddr == bus_m.FR_RAddr_2) ? bus_m.FR_Wdata : mdl[bus_m.FR_RAddr_2];
        if (mdl_busy) begin
            mdl[mdl_cnt] = 8'(mdl_cnt);
            if (mdl_cnt == DEP - 1) mdl_busy = 1'b0;
            mdl_cnt++;
        end else begin
            if (wr_ok) mdl[bus_m.FR_Waddr] = bus_m.FR_Wdata;
            if (bus_m.FR_Clr) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 0;
            end
        end
        e.busy = mdl_busy;
        q_m.push_back(e);
    endtask

    // One clock: predict, take the edge, compare both instances' queued expectations.
    task automatic cyc(input string tag);
        exp_t e;
        mdl_step();
        @(posedge clk);
        #1;
        e = q_m.pop_front();
        chk({tag, ".rd1"}, 32'(bus_m.FR_Rdata_1), 32'(e.rd1));
        chk({tag, ".rd2"}, 32'(bus_m.FR_Rdata_2), 32'(e.rd2));
        chk({tag, ".busy"}, 32'(bus_m.FR_Busy), 32'(e.busy));
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk({tag, ".alt_rd1"}, 32'(bus_a.FR_Rdata_1), 32'(e.rd1));
            chk({tag, ".alt_rd2"}, 32'(bus_a.FR_Rdata_2), 32'(e.rd2));
            chk({tag, ".alt_busy"}, 32'(bus_a.FR_Busy), 32'(e.busy));
        end
    endtask

    task automatic drv_m(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic clr, input logic [4:0] r1, input logic [4:0] r2);
        bus_m.FR_WE      = we;
        bus_m.FR_Waddr   = wa;
        bus_m.FR_Wdata   = wd;
        bus_m.FR_Clr     = clr;
        bus_m.FR_RAddr_1 = r1;
        bus_m.FR_RAddr_2 = r2;
    endtask

    // Drive the alternate instance; port 2 always watches entry 19 (last live entry).
    task automatic drv_a(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic [4:0] r1, input logic [7:0] exp_rd1);
        exp_t e;
        bus_a.FR_WE      = we;
        bus_a.FR_Waddr   = wa;
        bus_a.FR_Wdata   = wd;
        bus_a.FR_Clr     = 1'b0;
        bus_a.FR_RAddr_1 = r1;
        bus_a.FR_RAddr_2 = 5'd19;
        e.rd1  = exp_rd1;
        e.rd2  = 8'd19;
        e.busy = 1'b0;
        q_a.push_back(e);
    endtask

    task automatic fill55();
        for (int a = 0; a < DEP; a++) begin
            drv_m(1'b1, 5'(a), 8'h55, 1'b0, 5'(a), 5'd0);
            cyc("fill");
        end
    endtask

    initial begin
        rst = 1'b1;
        drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'd5, 5'd9);
        bus_a.FR_WE = 1'b0; bus_a.FR_Waddr = 5'd0; bus_a.FR_Wdata = 8'h00;
        bus_a.FR_Clr = 1'b0; bus_a.FR_RAddr_1 = 5'd3; bus_a.FR_RAddr_2 = 5'd19;
        #1 rst = 1'b0;
        #2;
        chk("reset.rd1", 32'(bus_m.FR_Rdata_1), 32'h0);
        chk("reset.rd2", 32'(bus_m.FR_Rdata_2), 32'h0);
        chk("reset.busy", 32'(bus_m.FR_Busy), 32'h0);
        chk("reset.alt_rd1", 32'(bus_a.FR_Rdata_1), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_edge.rd1", 32'(bus_m.FR_Rdata_1), 32'h0);
        chk("reset_edge.rd2", 32'(bus_m.FR_Rdata_2), 32'h0);
        chk("reset_edge.alt_rd2", 32'(bus_a.FR_Rdata_2), 32'h0);
        rst = 1'b1;
        mdl_reset();

        // Power-on pattern on both ports, one cycle late.
        for (int a = 0; a < DEP; a++) begin
            drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'(a), 5'(DEP - 1 - a));
            cyc("rst_read");
            chk("rst_read.pattern", 32'(bus_m.FR_Rdata_1), 32'(a));
        end

        // Same-edge write forwarded to the read port.
        drv_m(1'b1, 5'd7, 8'hA5, 1'b0, 5'd7, 5'd8);
        cyc("bypass");
        chk("bypass.const", 32'(bus_m.FR_Rdata_1), 32'hA5);
        drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'd7, 5'd7);
        cyc("bypass_after");

        // Alternate instance: no forwarding, DEPTH=20, hardwired entry 0.
        drv_a(1'b1, 5'd7, 8'hA5, 5'd7, 8'h07);
        cyc("alt_nobyp");
        drv_a(1'b0, 5'd0, 8'h00, 5'd7, 8'hA5);
        cyc("alt_nobyp_next");
        drv_a(1'b1, 5'd25, 8'h3C, 5'd25, 8'h00);
        cyc("alt_oob_wr");
        drv_a(1'b0, 5'd0, 8'h00, 5'd25, 8'h00);
        cyc("alt_oob_rd");
        drv_a(1'b1, 5'd0, 8'hFF, 5'd0, 8'h00);
        cyc("alt_r0_wr");
        drv_a(1'b0, 5'd0, 8'h00, 5'd0, 8'h00);
        cyc("alt_r0_rd");
        drv_a(1'b1, 5'd19, 8'h4B, 5'd19, 8'd19);
        cyc("alt_last_wr");
        bus_a.FR_WE = 1'b0;
        chk("alt_last_rd", 32'(bus_a.FR_Rdata_2), 32'd19);

        // Clear sweep: dropped write, ignored second clear, busy length.
        fill55();
        drv_m(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 5'd0);
        cyc("clr");
        busy_cnt = int'(bus_m.FR_Busy);
        for (int k = 0; k < 40; k++) begin
            drv_m(k == 4, 5'd3, 8'h99, k == 10, 5'd3, 5'(k));
            cyc("sweep");
            busy_cnt += int'(bus_m.FR_Busy);
        end
        chk("sweep.busy_len", 32'(busy_cnt), 32'd32);
        for (int a = 0; a < DEP; a++) begin
            drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'(a), 5'(a));
            cyc("post_sweep");
            chk("post_sweep.pattern", 32'(bus_m.FR_Rdata_2), 32'(a));
        end

        // Clear and write on the same idle edge: write lands, sweep overwrites later.
        drv_m(1'b1, 5'd5, 8'hEE, 1'b1, 5'd5, 5'd6);
        cyc("clr_we");
        chk("clr_we.const", 32'(bus_m.FR_Rdata_1), 32'hEE);
        for (int k = 0; k < 34; k++) begin
            drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'd5, 5'd0);
            cyc("clr_we_drain");
        end
        chk("clr_we.restored", 32'(bus_m.FR_Rdata_1), 32'd5);

        // Reset in the middle of a sweep.
        fill55();
        drv_m(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 5'd21);
        cyc("clr2");
        for (int k = 0; k < 10; k++) begin
            drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'd20, 5'd21);
            cyc("sweep2");
        end
        rst = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus_m.FR_Busy), 32'h0);
        chk("midrst.rd1", 32'(bus_m.FR_Rdata_1), 32'h0);
        chk("midrst.rd2", 32'(bus_m.FR_Rdata_2), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_edge.busy", 32'(bus_m.FR_Busy), 32'h0);
        chk("midrst_edge.rd1", 32'(bus_m.FR_Rdata_1), 32'h0);
        rst = 1'b1;
        mdl_reset();
        for (int a = 0; a < DEP; a++) begin
            drv_m(1'b0, 5'd0, 8'h00, 1'b0, 5'(a), 5'(DEP - 1 - a));
            cyc("midrst_read");
            chk("midrst_read.pattern", 32'(bus_m.FR_Rdata_1), 32'(a));
        end

        // Randomised dual-port traffic with occasional clear pulses.
        for (int n = 0; n < 10000; n++) begin
            drv_m(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 199) == 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
